// File: rtl/fft256_frame_ctrl.sv
// Frame controller for a streaming N-point FFT pipeline: zero-pads short
// input frames, limits frames in flight and tags result frame boundaries.
module fft256_frame_ctrl #(
  parameter int WIDTH        = 32,
  parameter int N            = 256,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_re,
  input  logic [WIDTH-1:0] s_im,
  output logic             fft_di_en,
  output logic [WIDTH-1:0] fft_di_re,
  output logic [WIDTH-1:0] fft_di_im,
  input  logic             fft_do_en,
  input  logic [WIDTH-1:0] fft_do_re,
  input  logic [WIDTH-1:0] fft_do_im,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_re,
  output logic [WIDTH-1:0] m_im,
  output logic             m_sof,
  output logic             m_eof,
  output logic [3:0]       inflight,
  output logic [15:0]      frames_out,
  output logic             err_gap,
  output logic             err_overflow,
  input  logic             err_clr
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [3:0] MAXI = 4'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    PAD
  } state_t;

  state_t        state;
  logic [IW-1:0] in_idx;
  logic [IW-1:0] out_idx;
  logic          admit;
  logic          done;
  logic          ovf_hit;

  always_comb begin
    s_ready = 1'b0;
    unique case (state)
      IDLE:    s_ready = (inflight < MAXI);
      FILL:    s_ready = 1'b1;
      default: s_ready = 1'b0;
    endcase
  end

  assign admit   = (state == IDLE) && s_valid && s_ready;
  assign done    = fft_do_en && (out_idx == LAST) && (inflight != '0);
  assign ovf_hit = fft_do_en && (inflight == '0);

  // Input side: every admitted frame yields exactly N pipeline samples
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_idx    <= '0;
      fft_di_en <= 1'b0;
      fft_di_re <= '0;
      fft_di_im <= '0;
      err_gap   <= 1'b0;
    end else begin
      fft_di_en <= 1'b0;
      if (err_clr) err_gap <= 1'b0;
      unique case (state)
        IDLE: begin
          if (admit) begin
            fft_di_en <= 1'b1;
            fft_di_re <= s_re;
            fft_di_im <= s_im;
            in_idx    <= IW'(1);
            state     <= FILL;
          end
        end
        FILL: begin
          fft_di_en <= 1'b1;
          if (s_valid) begin
            fft_di_re <= s_re;
            fft_di_im <= s_im;
          end else begin
            fft_di_re <= '0;
            fft_di_im <= '0;
            err_gap   <= 1'b1;
          end
          if (in_idx == LAST) begin
            in_idx <= '0;
            state  <= IDLE;
          end else begin
            in_idx <= in_idx + IW'(1);
            if (!s_valid) state <= PAD;
          end
        end
        PAD: begin
          fft_di_en <= 1'b1;
          fft_di_re <= '0;
          fft_di_im <= '0;
          if (in_idx == LAST) begin
            in_idx <= '0;
            state  <= IDLE;
          end else begin
            in_idx <= in_idx + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output side: frame tagging, completion accounting, overflow detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_valid      <= 1'b0;
      m_re         <= '0;
      m_im         <= '0;
      m_sof        <= 1'b0;
      m_eof        <= 1'b0;
      out_idx      <= '0;
      inflight     <= '0;
      frames_out   <= '0;
      err_overflow <= 1'b0;
    end else begin
      m_valid <= fft_do_en;
      m_sof   <= 1'b0;
      m_eof   <= 1'b0;
      if (fft_do_en) begin
        m_re  <= fft_do_re;
        m_im  <= fft_do_im;
        m_sof <= (out_idx == '0);
        m_eof <= (out_idx == LAST);
        if (out_idx == LAST) begin
          out_idx    <= '0;
          frames_out <= frames_out + 16'd1;
        end else begin
          out_idx <= out_idx + IW'(1);
        end
      end
      inflight <= inflight + {3'b000, admit} - {3'b000, done};
      if (err_clr) err_overflow <= 1'b0;
      if (ovf_hit) err_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft256_frame_ctrl.sv
// Bench for fft256_frame_ctrl: vector table, directed frame sequences and
// a randomized run against a frame-level reference model.
module tb_fft256_frame_ctrl;

  localparam int WIDTH = 32;
  localparam int N     = 256;
  localparam int MAXF  = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_re;
  logic [WIDTH-1:0] s_im;
  logic             fft_di_en;
  logic [WIDTH-1:0] fft_di_re;
  logic [WIDTH-1:0] fft_di_im;
  logic             fft_do_en;
  logic [WIDTH-1:0] fft_do_re;
  logic [WIDTH-1:0] fft_do_im;
  logic             m_valid;
  logic [WIDTH-1:0] m_re;
  logic [WIDTH-1:0] m_im;
  logic             m_sof;
  logic             m_eof;
  logic [3:0]       inflight;
  logic [15:0]      frames_out;
  logic             err_gap;
  logic             err_overflow;
  logic             err_clr;

  int n_chk;
  int n_fail;

  fft256_frame_ctrl #(
    .WIDTH(WIDTH),
    .N(N),
    .MAX_INFLIGHT(MAXF)
  ) dut (
    .clock(clock),
    .reset(reset),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_re(s_re),
    .s_im(s_im),
    .fft_di_en(fft_di_en),
    .fft_di_re(fft_di_re),
    .fft_di_im(fft_di_im),
    .fft_do_en(fft_do_en),
    .fft_do_re(fft_do_re),
    .fft_do_im(fft_do_im),
    .m_valid(m_valid),
    .m_re(m_re),
    .m_im(m_im),
    .m_sof(m_sof),
    .m_eof(m_eof),
    .inflight(inflight),
    .frames_out(frames_out),
    .err_gap(err_gap),
    .err_overflow(err_overflow),
    .err_clr(err_clr)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, %0d checks so far", n_chk);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Frame-level reference model: counts delivered samples per frame and
  // result samples overall, deriving frame tags by modulo arithmetic.
  int               md_pos;
  bit               md_pad;
  int               md_infl;
  int               md_outcnt;
  int               md_frames;
  bit               md_gap;
  bit               md_ovf;
  bit               e_di_en;
  logic [WIDTH-1:0] e_di_re;
  logic [WIDTH-1:0] e_di_im;
  bit               e_mv;
  logic [WIDTH-1:0] e_mre;
  logic [WIDTH-1:0] e_mim;
  bit               e_sof;
  bit               e_eof;

  task automatic model_reset();
    md_pos = 0; md_pad = 0; md_infl = 0; md_outcnt = 0; md_frames = 0;
    md_gap = 0; md_ovf = 0; e_di_en = 0; e_di_re = '0; e_di_im = '0;
    e_mv = 0; e_mre = '0; e_mim = '0; e_sof = 0; e_eof = 0;
  endtask

  task automatic model_step(output bit rdy);
    int  old;
    bit  adm;
    bit  cmp;
    bit  gset;
    old  = md_infl;
    rdy  = (md_pos == 0) ? (md_infl < MAXF) : !md_pad;
    adm  = (md_pos == 0) && s_valid && rdy;
    gset = 0;
    cmp  = 0;
    e_di_en = 0;
    if (md_pos == 0) begin
      if (adm) begin
        e_di_en = 1; e_di_re = s_re; e_di_im = s_im; md_pos = 1;
      end
    end else begin
      e_di_en = 1;
      if (!md_pad && s_valid) begin
        e_di_re = s_re; e_di_im = s_im;
      end else begin
        e_di_re = '0; e_di_im = '0;
        if (!md_pad) gset = 1;
        md_pad = 1;
      end
      md_pos++;
      if (md_pos == N) begin
        md_pos = 0; md_pad = 0;
      end
    end
    if (err_clr) md_gap = 0;
    if (gset) md_gap = 1;
    e_mv = fft_do_en; e_sof = 0; e_eof = 0;
    if (fft_do_en) begin
      e_mre = fft_do_re; e_mim = fft_do_im;
      e_sof = (md_outcnt % N == 0);
      e_eof = (md_outcnt % N == N - 1);
      if (e_eof) begin
        md_frames = (md_frames + 1) % 65536;
        cmp = (old > 0);
      end
      md_outcnt++;
    end
    md_infl = old + int'(adm) - int'(cmp);
    if (err_clr) md_ovf = 0;
    if (fft_do_en && old == 0) md_ovf = 1;
  endtask

  task automatic do_reset();
    reset = 1'b1; s_valid = 1'b0; fft_do_en = 1'b0; err_clr = 1'b0;
    s_re = '0; s_im = '0; fft_do_re = '0; fft_do_im = '0;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, s_ready, 1);
    chk({tag, "_di_en"}, fft_di_en, 0);
    chk({tag, "_di_data"}, {fft_di_re, fft_di_im}, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"}, {m_re, m_im}, 0);
    chk({tag, "_sof_eof"}, {m_sof, m_eof}, 0);
    chk({tag, "_inflight"}, inflight, 0);
    chk({tag, "_frames"}, frames_out, 0);
    chk({tag, "_errs"}, {err_gap, err_overflow}, 0);
  endtask

  typedef struct {
    logic sv;
    logic de;
    logic clr;
    logic rdy;
    logic mv;
    logic sof;
    logic ovf;
    logic gap;
    logic di;
    int   infl;
  } vec_t;

  vec_t tbl[7];

  initial begin
    bit rdy;
    int zeros;
    n_chk  = 0;
    n_fail = 0;

    do_reset();
    chk_reset_state("rst");

    // sv de clr | rdy mv sof ovf gap di infl
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    for (int i = 0; i < 7; i++) begin
      s_valid = tbl[i].sv; fft_do_en = tbl[i].de; err_clr = tbl[i].clr;
      s_re = 32'(i + 1); fft_do_re = 32'(i + 50);
      chk($sformatf("tbl%0d_ready", i), s_ready, tbl[i].rdy);
      cyc();
      chk($sformatf("tbl%0d_m_valid", i), m_valid, tbl[i].mv);
      chk($sformatf("tbl%0d_sof", i), m_sof, tbl[i].sof);
      chk($sformatf("tbl%0d_ovf", i), err_overflow, tbl[i].ovf);
      chk($sformatf("tbl%0d_gap", i), err_gap, tbl[i].gap);
      chk($sformatf("tbl%0d_di_en", i), fft_di_en, tbl[i].di);
      chk($sformatf("tbl%0d_inflight", i), inflight, 64'(tbl[i].infl));
    end
    err_clr = 1'b0;

    // Continuous input: two frames admitted, third stalls
    do_reset();
    s_valid = 1'b1;
    for (int c = 0; c < 3 * N + 4; c++) begin
      s_re = 32'(c); s_im = ~32'(c);
      chk("cont_ready", s_ready, c < 2 * N);
      cyc();
      chk("cont_di_en", fft_di_en, c < 2 * N);
      if (c < 2 * N) chk("cont_di_data", {fft_di_re, fft_di_im},
                         {32'(c), ~32'(c)});
      if (c == 0) chk("cont_inflight1", inflight, 1);
    end
    chk("cont_inflight2", inflight, 2);
    chk("cont_gap", err_gap, 0);

    // Drain frame 1 through the output side
    s_valid = 1'b0;
    for (int p = 0; p < N; p++) begin
      fft_do_en = 1'b1; fft_do_re = 32'(p * 7 + 5); fft_do_im = 32'(p * 3);
      cyc();
      chk("out_valid", m_valid, 1);
      chk("out_data", {m_re, m_im}, {32'(p * 7 + 5), 32'(p * 3)});
      chk("out_sof", m_sof, p == 0);
      chk("out_eof", m_eof, p == N - 1);
    end
    fft_do_en = 1'b0;
    fft_do_re = 32'hDEAD;
    cyc();
    chk("out_idle_valid", m_valid, 0);
    chk("out_hold", m_re, 32'((N - 1) * 7 + 5));
    chk("out_idle_eof", m_eof, 0);
    chk("out_frames1", frames_out, 1);
    chk("out_inflight1", inflight, 1);

    // Last result sample of frame 2 coincides with admitting frame 3
    s_re = 32'hABCD0000;
    for (int p = 0; p < N; p++) begin
      fft_do_en = 1'b1;
      s_valid = (p == N - 1);
      if (p == N - 1) chk("same_ready", s_ready, 1);
      cyc();
    end
    chk("same_inflight", inflight, 1);
    chk("same_frames", frames_out, 2);
    chk("same_di", {fft_di_en, fft_di_re}, {1'b1, 32'hABCD0000});
    fft_do_en = 1'b0;
    s_valid = 1'b1;
    for (int k = 1; k < N; k++) cyc();
    s_valid = 1'b0;
    cyc();
    chk("f3_di_en", fft_di_en, 0);
    chk("f3_errs", {err_gap, err_overflow}, 0);
    chk("f3_inflight", inflight, 1);
    fft_do_en = 1'b1;
    for (int p = 0; p < N; p++) cyc();
    fft_do_en = 1'b0;
    cyc();
    chk("f3_done_inflight", inflight, 0);
    chk("f3_done_frames", frames_out, 3);
    chk("f3_done_ovf", err_overflow, 0);

    // Source gap at sample 100: remainder padded with zeros
    do_reset();
    zeros = 0;
    for (int c = 0; c < N + 4; c++) begin
      s_valid = (c < 100);
      s_re = 32'(c + 1); s_im = 32'(c + 9);
      chk("gap_ready", s_ready, (c <= 100) || (c >= N));
      cyc();
      chk("gap_di_en", fft_di_en, c < N);
      if (c < 100) chk("gap_di_data", fft_di_re, 32'(c + 1));
      if (c >= 100 && c < N) begin
        chk("gap_zero", {fft_di_re, fft_di_im}, 0);
        if (fft_di_en && fft_di_re == '0 && fft_di_im == '0) zeros++;
      end
      if (c == 100) chk("gap_flag", err_gap, 1);
    end
    chk("gap_zero_count", 64'(zeros), 156);
    chk("gap_sticky", err_gap, 1);
    chk("gap_inflight", inflight, 1);

    // Asynchronous reset in the middle of a frame
    do_reset();
    s_valid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      s_re = 32'(c + 77); s_im = 32'(c + 3);
      fft_do_en = (c == 49); fft_do_re = 32'h1234; fft_do_im = 32'h55;
      cyc();
    end
    chk("pre_rst_sof", {m_valid, m_sof}, 2'b11);
    s_valid = 1'b0; fft_do_en = 1'b0;
    #3 reset = 1'b1;
    #1;
    chk_reset_state("midrst");
    @(posedge clock);
    #1 reset = 1'b0;
    for (int c = 0; c < N + 40; c++) begin
      chk("post_rst_ready", s_ready, 1);
      cyc();
      chk("post_rst_di_en", fft_di_en, 0);
    end
    chk("post_rst_gap", err_gap, 0);
    chk("post_rst_inflight", inflight, 0);

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 8000; i++) begin
      int gap_pct;
      gap_pct = ((i / 1000) % 2 == 1) ? 0 : 2;
      s_valid   = ($urandom_range(0, 99) >= gap_pct);
      s_re      = $urandom;
      s_im      = $urandom;
      fft_do_en = ($urandom_range(0, 99) < 45);
      fft_do_re = $urandom;
      fft_do_im = $urandom;
      err_clr   = ($urandom_range(0, 99) < 3);
      model_step(rdy);
      chk("rnd_ready", s_ready, rdy);
      cyc();
      chk("rnd_di_en", fft_di_en, e_di_en);
      chk("rnd_di_data", {fft_di_re, fft_di_im}, {e_di_re, e_di_im});
      chk("rnd_m_valid", m_valid, e_mv);
      chk("rnd_m_data", {m_re, m_im}, {e_mre, e_mim});
      chk("rnd_sof_eof", {m_sof, m_eof}, {e_sof, e_eof});
      chk("rnd_inflight", inflight, 64'(md_infl));
      chk("rnd_frames", frames_out, 64'(md_frames));
      chk("rnd_errs", {err_gap, err_overflow}, {md_gap, md_ovf});
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fft256_frame_ctrl.md
FFT256_FRAME_CTRL -- requirements
Module: fft256_frame_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, sample component width in bits.
REQ-002 SHALL have parameter N, default 256, samples per FFT frame.
REQ-003 SHALL have parameter MAX_INFLIGHT, default 2, maximum frames admitted to the pipeline and not yet fully output; legal range 1..15.
REQ-004 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-005 Port list:
clock  in  1  master clock
reset  in  1  asynchronous active-high reset
s_valid  in  1  source sample valid
s_ready  out  1  controller accepts sample
s_re / s_im  in  WIDTH  source sample real / imag
fft_di_en  out  1  pipeline input enable
fft_di_re / fft_di_im  out  WIDTH  pipeline input data
fft_do_en  in  1  pipeline output enable
fft_do_re / fft_do_im  in  WIDTH  pipeline output data
m_valid  out  1  result sample valid; no backpressure
m_re / m_im  out  WIDTH  result data
m_sof / m_eof  out  1  first / last result sample of a frame, qualified by m_valid
inflight  out  4  frames admitted, not yet completed
frames_out  out  16  completed output frames, wraps at 65535 to 0
err_gap  out  1  sticky: s_valid low during an admitted frame
err_overflow  out  1  sticky: fft_do_en with inflight = 0
err_clr  in  1  synchronous clear of both sticky errors

Function
REQ-006 Input FSM SHALL have states IDLE, FILL, PAD.
REQ-007 IDLE: s_ready = 1 iff inflight < MAX_INFLIGHT; s_valid && s_ready admits sample 0, increments inflight, and enters FILL with in_idx = 1.
REQ-008 FILL: s_ready = 1; each accepted sample increments in_idx; the accept at in_idx = N-1 returns to IDLE.
REQ-009 FILL with s_valid = 0 SHALL set err_gap and enter PAD in the same cycle, emitting a zero sample on the pipeline input for that cycle.
REQ-010 PAD: s_ready = 0; SHALL emit zero samples (fft_di_en = 1, data 0) until in_idx reaches N-1, then return to IDLE; a frame therefore always delivers exactly N contiguous fft_di_en cycles.
REQ-011 fft_di_en/re/im SHALL be registered: one-cycle latency from a source accept (or pad cycle) to the pipeline input; fft_di_en = 0 in IDLE with no accept.
REQ-012 Output path SHALL register fft_do_* into m_valid/m_re/m_im with one-cycle latency; m_re/m_im SHALL hold their last value when m_valid = 0.
REQ-013 out_idx counter SHALL advance on each fft_do_en, wrapping N-1 to 0; m_sof = 1 when out_idx = 0, m_eof = 1 when out_idx = N-1.
REQ-014 On the fft_do_en where out_idx = N-1: decrement inflight and increment frames_out.
REQ-015 Same-cycle admit (REQ-007) and completion (REQ-014) SHALL leave inflight unchanged.
REQ-016 fft_do_en with inflight = 0 SHALL set err_overflow, still forward the sample to m_*, and not change inflight.
REQ-017 err_clr SHALL clear both sticky errors; a same-cycle set condition takes priority over err_clr.
REQ-018 s_ready SHALL be combinational from state and inflight only, never from s_valid.

Reset
REQ-019 Reset SHALL force IDLE, in_idx = 0, out_idx = 0, inflight = 0, frames_out = 0, and err_gap, err_overflow, fft_di_en, m_valid, m_sof, m_eof, fft_di_re/im, m_re/m_im all 0; s_ready = 1 after reset release.
REQ-020 Reset asserted mid-frame SHALL abandon both partial frames; no pad completion follows reset release.

Verification
REQ-021 Continuous 256 samples, s_valid held 1 -> fft_di_en high 256 cycles starting 1 cycle after the first accept; inflight = 1; err_gap = 0.
REQ-022 MAX_INFLIGHT = 2, three back-to-back frames, no pipeline output -> s_ready drops after sample 511; frame 3 stalls; inflight = 2.
REQ-023 s_valid drops at sample 100 -> err_gap = 1; 156 zero samples padded; s_ready = 0 until in_idx reaches N-1.
REQ-024 Model 256 fft_do_en pulses with inflight = 1 -> m_sof on the first m_valid, m_eof on the 256th; frames_out = 1; inflight = 0.
REQ-025 Admit sample 0 of a new frame in the same cycle as the last fft_do_en of the prior frame -> inflight stays 1.
REQ-026 fft_do_en after reset with no frames admitted -> err_overflow = 1; err_clr clears it next cycle; reset mid-FILL -> all outputs return to the REQ-019 values.
